// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Byte-stream command parser sitting between the UART wrapper and the waveform core.
//   Host frames: SYNC, CMD, P3, P2, P1, P0, CSUM  (payload big-endian,
//   CSUM = CMD ^ P3 ^ P2 ^ P1 ^ P0). Accepted frames update signalNumber / adder /
//   amplitude and are answered with ACK_BYTE; rejected frames are answered with NAK_BYTE.
//   CMD 0x04 answers ACK followed by the 4 bytes of `signal` (MSB first), as sampled in
//   the cycle right after the checksum byte.
//
// Optional feature (compile-time macro UART_CMD_TIMEOUT_EN):
//   When defined, a frame that stalls for TIMEOUT_CYCLES cycles between bytes is
//   abandoned silently. When undefined, the parser waits indefinitely.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   from_uart_data/valid/error received byte stream (ready is an output)
//   to_uart_data/valid/error   transmit byte stream (ready is an input; error tied 0)
//   signal                     current waveform sample for readback
//   signalNumber, adder,
//   amplitude                  waveform parameter registers
//   cfg_update                 one-cycle pulse on any parameter register write
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 32'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  from_uart_data,
  input  logic        from_uart_valid,
  input  logic        from_uart_error,
  output logic        from_uart_ready,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  output logic        to_uart_error,
  input  logic        to_uart_ready,
  input  logic [31:0] signal,
  output logic [7:0]  signalNumber,
  output logic [31:0] adder,
  output logic [31:0] amplitude,
  output logic        cfg_update
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;
  localparam logic [2:0] ST_RDBK    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] payload_q, payload_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;        // running XOR of CMD and payload bytes
  logic        bad_q, bad_d;          // sticky: some byte of this frame had a UART error
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] rdbk_q, rdbk_d;        // readback holding / shift register
  logic [1:0]  rd_cnt_q, rd_cnt_d;    // readback bytes still to send after the current one
  logic        rdbk_pend_q, rdbk_pend_d;
  logic [7:0]  sig_num_q, sig_num_d;
  logic [31:0] adder_q, adder_d;
  logic [31:0] amp_q, amp_d;
  logic        cfg_update_q, cfg_update_d;

  logic        byte_acc;
  logic        tx_done;
  logic        frame_ok;
  logic        rx_state;
  logic [31:0] rsp_src;

  // Receiving states accept bytes; reset gates ready low while asserted.
  assign rx_state = (state_q == ST_IDLE) || (state_q == ST_CMD) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign from_uart_ready = reset && rx_state;

  assign byte_acc = from_uart_valid && from_uart_ready;
  assign tx_done  = tx_valid_q && to_uart_ready;

  // Evaluated only while the checksum byte is being accepted.
  assign frame_ok = (from_uart_data == csum_q) && !bad_q && !from_uart_error &&
                    (cmd_q >= 8'h01) && (cmd_q <= 8'h04);

  // In EXEC the sample is taken straight from the input so an immediate handshake
  // still returns the EXEC-cycle value.
  assign rsp_src = (state_q == ST_EXEC) ? signal : rdbk_q;

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    payload_d    = payload_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    bad_d        = bad_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    rdbk_d       = rdbk_q;
    rd_cnt_d     = rd_cnt_q;
    rdbk_pend_d  = rdbk_pend_q;
    sig_num_d    = sig_num_q;
    adder_d      = adder_q;
    amp_d        = amp_q;
    cfg_update_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_acc && !from_uart_error && (from_uart_data == SYNC_BYTE)) begin
          state_d = ST_CMD;
          bad_d   = 1'b0;
        end
      end

      ST_CMD: begin
        if (byte_acc) begin
          cmd_d   = from_uart_data;
          csum_d  = from_uart_data;
          bad_d   = bad_q | from_uart_error;
          idx_d   = 2'd0;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (byte_acc) begin
          payload_d = {payload_q[23:0], from_uart_data};
          csum_d    = csum_q ^ from_uart_data;
          bad_d     = bad_q | from_uart_error;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (byte_acc) begin
          // Decision is registered here so writes, cfg_update and the response
          // byte are all visible during the EXEC cycle.
          state_d     = ST_EXEC;
          tx_valid_d  = 1'b1;
          rdbk_pend_d = 1'b0;
          if (frame_ok) begin
            tx_data_d = ACK_BYTE;
            case (cmd_q)
              8'h01: begin
                sig_num_d    = payload_q[7:0];
                cfg_update_d = 1'b1;
              end
              8'h02: begin
                adder_d      = payload_q;
                cfg_update_d = 1'b1;
              end
              8'h03: begin
                amp_d        = payload_q;
                cfg_update_d = 1'b1;
              end
              default: rdbk_pend_d = 1'b1;
            endcase
          end else begin
            tx_data_d = NAK_BYTE;
          end
        end
      end

      ST_EXEC, ST_RESP: begin
        if ((state_q == ST_EXEC) && rdbk_pend_q) begin
          rdbk_d = signal;
        end
        if (tx_done) begin
          if (rdbk_pend_q) begin
            tx_data_d   = rsp_src[31:24];
            rdbk_d      = {rsp_src[23:0], 8'h00};
            rd_cnt_d    = 2'd3;
            rdbk_pend_d = 1'b0;
            state_d     = ST_RDBK;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_RDBK: begin
        if (tx_done) begin
          if (rd_cnt_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            tx_data_d = rdbk_q[31:24];
            rdbk_d    = {rdbk_q[23:0], 8'h00};
            rd_cnt_d  = rd_cnt_q - 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    to_cnt_d = 32'd0;
    if ((state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM)) begin
      if (byte_acc) begin
        to_cnt_d = 32'd0;
      end else if (to_cnt_q == (TIMEOUT_CYCLES - 32'd1)) begin
        state_d  = ST_IDLE;
        bad_d    = 1'b0;
        to_cnt_d = 32'd0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      payload_q    <= 32'h0;
      idx_q        <= 2'd0;
      csum_q       <= 8'h00;
      bad_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      rdbk_q       <= 32'h0;
      rd_cnt_q     <= 2'd0;
      rdbk_pend_q  <= 1'b0;
      sig_num_q    <= 8'h00;
      adder_q      <= 32'h0;
      amp_q        <= 32'h0;
      cfg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      payload_q    <= payload_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      bad_q        <= bad_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rdbk_q       <= rdbk_d;
      rd_cnt_q     <= rd_cnt_d;
      rdbk_pend_q  <= rdbk_pend_d;
      sig_num_q    <= sig_num_d;
      adder_q      <= adder_d;
      amp_q        <= amp_d;
      cfg_update_q <= cfg_update_d;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign to_uart_data  = tx_data_q;
  assign to_uart_valid = tx_valid_q;
  assign to_uart_error = 1'b0;
  assign signalNumber  = sig_num_q;
  assign adder         = adder_q;
  assign amplitude     = amp_q;
  assign cfg_update    = cfg_update_q;

endmodule
